// File: rtl/i2c_slave_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder_pkg
// Description : Shared types and constants for the I2C target responder:
//               FSM state encoding, ACK/NACK encoding, open-drain enable
//               polarity and bit-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_slave_responder_pkg;

  // Protocol states of the target FSM
  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    SLAVE_ADDR     = 4'd1,
    SLAVE_ADDR_ACK = 4'd2,
    REG_ADDR       = 4'd3,
    REG_ADDR_ACK   = 4'd4,
    WR_DATA        = 4'd5,
    WR_DATA_ACK    = 4'd6,
    RD_DATA        = 4'd7,
    RD_DATA_ACK    = 4'd8,
    WAIT_STOP      = 4'd9
  } i2c_slave_state_e;

  // Level seen on SDA during the 9th clock
  typedef enum logic {
    POS_ACK = 1'b0,
    NEG_ACK = 1'b1
  } acknowledge_e;

  // sda_oen polarity: ON pulls the line low, OFF releases it
  localparam logic TRISTATE_BUF_ON  = 1'b1;
  localparam logic TRISTATE_BUF_OFF = 1'b0;

  // Bits are counted 0..7 within a byte
  localparam int                     BIT_CNT_WIDTH = 3;
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT    = 3'd7;

endpackage : i2c_slave_responder_pkg
`default_nettype wire

// File: rtl/i2c_slave_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder_if
// Description : Bundles the I2C pins and the register-access port of the
//               target. The slave modport is the responder's view; the
//               master modport is the view of whoever drives the pins and
//               supplies read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_responder_if #(
  parameter int REGISTER_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH             = 8
);

  logic                              scl_i;
  logic                              sda_i;
  logic                              sda_oen;
  logic                              busy;
  logic                              wr_en;
  logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]             rd_data;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_oen, busy, wr_en, wr_addr, wr_data, rd_addr
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_oen, busy, wr_en, wr_addr, wr_data, rd_addr
  );

endinterface : i2c_slave_responder_if
`default_nettype wire

// File: rtl/i2c_slave_responder_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Brings the asynchronous SCL/SDA pins into the pclk domain
//               through a 2-flop synchronizer, keeps one extra history flop
//               per line and decodes SCL edges plus START/STOP conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
  input  logic pclk,
  input  logic areset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;
  logic       w_scl;
  logic       w_sda;

  // Synchronizer and history flops; reset to the idle-bus level (both high)
  // so that leaving reset never fakes an edge or a START.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign w_scl = scl_sync_q[1];
  assign w_sda = sda_sync_q[1];

  assign sda_s     = w_sda;
  assign scl_rise  =  w_scl & ~scl_hist_q;
  assign scl_fall  = ~w_scl &  scl_hist_q;
  // SDA may only change while SCL is high for START/STOP, so SCL must be
  // high both now and in the previous sample.
  assign start_det = w_scl & scl_hist_q &  sda_hist_q & ~w_sda;
  assign stop_det  = w_scl & scl_hist_q & ~sda_hist_q &  w_sda;

endmodule : i2c_bus_sync
`default_nettype wire

// File: rtl/i2c_slave_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_responder
// Description : I2C target. Decodes START, 7-bit address + R/W, a register
//               address byte and data bytes; issues register write strobes,
//               serves read data from an attached register file and drives
//               ACK/read bits through an open-drain SDA enable.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_responder
  import i2c_slave_responder_pkg::*;
#(
  parameter int                             SLAVE_ADDRESS_WIDTH    = 7,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS          = 7'h68,
  parameter int                             REGISTER_ADDRESS_WIDTH = 8,
  parameter int                             DATA_WIDTH             = 8,
  parameter int                             NO_OF_REG              = 4
) (
  input  logic                 pclk,
  input  logic                 areset,
  i2c_slave_responder_if.slave bus
);

  localparam logic [REGISTER_ADDRESS_WIDTH-1:0] LAST_REG =
    REGISTER_ADDRESS_WIDTH'(NO_OF_REG - 1);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_bus_sync u_bus_sync (
    .pclk      (pclk),
    .areset    (areset),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_slave_state_e                  state_q,   state_d;
  logic [BIT_CNT_WIDTH-1:0]          cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0]             sh_q,      sh_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] ptr_q,     ptr_d;
  logic                              rw_q,      rw_d;
  logic                              nine_q,    nine_d;   // 9th SCL rise seen
  acknowledge_e                      ack_q,     ack_d;
  logic                              oen_q,     oen_d;
  logic                              busy_q,    busy_d;
  logic                              wr_en_q,   wr_en_d;
  logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]             wr_data_q, wr_data_d;

  logic [DATA_WIDTH-1:0]             w_byte;
  logic                              w_last_bit;
  logic                              w_addr_match;
  logic                              w_reg_ok;
  logic [REGISTER_ADDRESS_WIDTH-1:0] w_ptr_next;
  logic                              w_rd_oen;

  // Byte as it stands once the bit being sampled now is shifted in
  assign w_byte       = {sh_q[DATA_WIDTH-2:0], sda_s};
  assign w_last_bit   = (cnt_q == LAST_BIT);
  assign w_addr_match = (w_byte[SLAVE_ADDRESS_WIDTH:1] == SLAVE_ADDRESS);
  assign w_reg_ok     = ({24'd0, w_byte} < 32'(NO_OF_REG));
  assign w_ptr_next   = (ptr_q == LAST_REG) ? '0
                                            : ptr_q + REGISTER_ADDRESS_WIDTH'(1);
  // First read bit comes straight from the register file
  assign w_rd_oen     = bus.rd_data[DATA_WIDTH-1] ? TRISTATE_BUF_OFF
                                                  : TRISTATE_BUF_ON;

  // State and datapath registers
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      nine_q    <= 1'b0;
      ack_q     <= NEG_ACK;
      oen_q     <= TRISTATE_BUF_OFF;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      nine_q    <= nine_d;
      ack_q     <= ack_d;
      oen_q     <= oen_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state decode; bus conditions take priority over bit processing
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = SLAVE_ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        SLAVE_ADDR:
          if (scl_rise && w_last_bit)
            state_d = w_addr_match ? SLAVE_ADDR_ACK : WAIT_STOP;
        SLAVE_ADDR_ACK:
          if (scl_fall && nine_q)
            state_d = rw_q ? RD_DATA : REG_ADDR;
        REG_ADDR:
          if (scl_rise && w_last_bit)
            state_d = w_reg_ok ? REG_ADDR_ACK : WAIT_STOP;
        REG_ADDR_ACK:
          if (scl_fall && nine_q) state_d = WR_DATA;
        WR_DATA:
          if (scl_rise && w_last_bit) state_d = WR_DATA_ACK;
        WR_DATA_ACK:
          if (scl_fall && nine_q) state_d = WR_DATA;
        RD_DATA:
          if (scl_rise && w_last_bit) state_d = RD_DATA_ACK;
        RD_DATA_ACK:
          if (scl_fall && nine_q)
            state_d = (ack_q == POS_ACK) ? RD_DATA : WAIT_STOP;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath and output updates for the current state and bus event
  always_comb begin
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    nine_d    = nine_q;
    ack_d     = ack_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_det) begin
      cnt_d  = '0;
      nine_d = 1'b0;
      oen_d  = TRISTATE_BUF_OFF;
      busy_d = 1'b1;
    end else if (stop_det) begin
      cnt_d  = '0;
      nine_d = 1'b0;
      oen_d  = TRISTATE_BUF_OFF;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        SLAVE_ADDR, REG_ADDR, WR_DATA, RD_DATA: begin
          if (scl_rise) begin
            // Counter wraps to 0 after the 8th bit, ready for the next byte
            sh_d   = w_byte;
            cnt_d  = cnt_q + BIT_CNT_WIDTH'(1);
            nine_d = 1'b0;
            if (w_last_bit) begin
              if (state_q == SLAVE_ADDR) rw_d = sda_s;
              if (state_q == REG_ADDR && w_reg_ok)
                ptr_d = w_byte[REGISTER_ADDRESS_WIDTH-1:0];
              if (state_q == WR_DATA) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = w_byte;
                ptr_d     = w_ptr_next;
              end
            end
          end
          // While reading, the next bit has moved up into the MSB
          if (scl_fall && state_q == RD_DATA)
            oen_d = sh_q[DATA_WIDTH-1] ? TRISTATE_BUF_OFF : TRISTATE_BUF_ON;
        end

        SLAVE_ADDR_ACK, REG_ADDR_ACK, WR_DATA_ACK: begin
          if (scl_rise) nine_d = 1'b1;
          if (scl_fall) begin
            if (!nine_q) begin
              oen_d = TRISTATE_BUF_ON;
            end else begin
              nine_d = 1'b0;
              if (state_q == SLAVE_ADDR_ACK && rw_q) begin
                sh_d  = bus.rd_data;
                oen_d = w_rd_oen;
              end else begin
                oen_d = TRISTATE_BUF_OFF;
              end
            end
          end
        end

        RD_DATA_ACK: begin
          // Pointer moves on the 9th rise so rd_data is valid at the fall
          if (scl_rise) begin
            nine_d = 1'b1;
            ack_d  = sda_s ? NEG_ACK : POS_ACK;
            if (!sda_s) ptr_d = w_ptr_next;
          end
          if (scl_fall) begin
            if (!nine_q) begin
              oen_d = TRISTATE_BUF_OFF;
            end else begin
              nine_d = 1'b0;
              if (ack_q == POS_ACK) begin
                sh_d  = bus.rd_data;
                oen_d = w_rd_oen;
              end else begin
                oen_d = TRISTATE_BUF_OFF;
              end
            end
          end
        end

        default: oen_d = TRISTATE_BUF_OFF;
      endcase
    end
  end

  assign bus.sda_oen = oen_q;
  assign bus.busy    = busy_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_addr = ptr_q;

endmodule : i2c_slave_responder
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_responder
// Description : Directed bench for the I2C target: a bit-banged master on
//               an open-drain SDA model, a small register file behind
//               rd_data and a write-strobe log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_responder;

  logic pclk   = 1'b0;
  logic areset = 1'b0;
  logic m_scl  = 1'b1;
  logic m_sda  = 1'b1;
  logic oen_seen = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] regs [4];
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];

  i2c_slave_responder_if #(.REGISTER_ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

  i2c_slave_responder #(
    .SLAVE_ADDRESS_WIDTH    (7),
    .SLAVE_ADDRESS          (7'h68),
    .REGISTER_ADDRESS_WIDTH (8),
    .DATA_WIDTH             (8),
    .NO_OF_REG              (4)
  ) dut (
    .pclk   (pclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  // Open-drain SDA: low if either side pulls it
  assign bus.scl_i   = m_scl;
  assign bus.sda_i   = m_sda & ~bus.sda_oen;
  assign bus.rd_data = (bus.rd_addr < 8'd4) ? regs[bus.rd_addr[1:0]] : 8'h00;

  // Log every pclk that carries a write strobe
  always @(negedge pclk) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
    end
    if (bus.sda_oen === 1'b1) oen_seen = 1'b1;
  end

  // ---------------- master primitives ----------------
  task automatic i2c_start();
    #50 m_sda = 1'b1;
    #50 m_scl = 1'b1;
    #100 m_sda = 1'b0;
    #100 m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #50 m_sda = 1'b0;
    #50 m_scl = 1'b1;
    #100 m_sda = 1'b1;
    #100;
  endtask

  task automatic send_bit(input logic b);
    #50 m_sda = b;
    #50 m_scl = 1'b1;
    #100 m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #50 m_sda = 1'b1;
    #50 m_scl = 1'b1;
    #50 b = bus.sda_i;
    #50 m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    oen_seen = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #23;
    chk_cnt++; if (bus.sda_oen !== 1'b0) $display("FAIL rst_oen: got %b want 0", bus.sda_oen); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); else pass_cnt++;
    chk_cnt++; if (bus.rd_addr !== 8'h00) $display("FAIL rst_rd_addr: got %h want 00", bus.rd_addr); else pass_cnt++;
    @(negedge pclk) areset = 1'b1;
    #200;
  endtask

  task automatic test_write_one();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'hD0, a0);
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL w1_busy: got %b want 1", bus.busy); else pass_cnt++;
    write_byte(8'h02, a1);
    write_byte(8'hA5, a2);
    i2c_stop();
    #100;
    chk_cnt++; if (a0 !== 1'b0) $display("FAIL w1_addr_ack: got %b want 0", a0); else pass_cnt++;
    chk_cnt++; if (a1 !== 1'b0) $display("FAIL w1_reg_ack: got %b want 0", a1); else pass_cnt++;
    chk_cnt++; if (a2 !== 1'b0) $display("FAIL w1_data_ack: got %b want 0", a2); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 1) $display("FAIL w1_wr_cycles: got %0d want 1", wq_addr.size()); else pass_cnt++;
    chk_cnt++; if (wq_addr[0] !== 8'h02) $display("FAIL w1_wr_addr: got %h want 02", wq_addr[0]); else pass_cnt++;
    chk_cnt++; if (wq_data[0] !== 8'hA5) $display("FAIL w1_wr_data: got %h want a5", wq_data[0]); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL w1_busy_stop: got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_read_ack_nack();
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    clear_logs();
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    #100;
    chk_cnt++; if (bus.sda_oen !== 1'b0) $display("FAIL rd_release: got %b want 0", bus.sda_oen); else pass_cnt++;
    chk_cnt++; if (bus.rd_addr !== 8'h00) $display("FAIL rd_ptr: got %h want 00", bus.rd_addr); else pass_cnt++;
    i2c_stop();
    chk_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); else pass_cnt++;
    chk_cnt++; if (d0 !== 8'h11) $display("FAIL rd_byte0: got %h want 11", d0); else pass_cnt++;
    chk_cnt++; if (d1 !== 8'h22) $display("FAIL rd_byte1: got %h want 22", d1); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 0) $display("FAIL rd_no_write: got %0d want 0", wq_addr.size()); else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    clear_logs();
    i2c_start();
    write_byte(8'hD8, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    #100;
    chk_cnt++; if ({a0, a1} !== 2'b11) $display("FAIL mm_nack: got %b want 11", {a0, a1}); else pass_cnt++;
    chk_cnt++; if (oen_seen !== 1'b0) $display("FAIL mm_oen: got %b want 0", oen_seen); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 0) $display("FAIL mm_no_write: got %0d want 0", wq_addr.size()); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL mm_busy: got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_reg_range();
    logic a0, a1, a2;
    clear_logs();
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h04, a1);
    write_byte(8'h55, a2);
    i2c_stop();
    #100;
    chk_cnt++; if ({a0, a1, a2} !== 3'b011) $display("FAIL rr_acks: got %b want 011", {a0, a1, a2}); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 0) $display("FAIL rr_no_write: got %0d want 0", wq_addr.size()); else pass_cnt++;
  endtask

  task automatic test_reset_recovery();
    logic a0, a1, a2, b;
    clear_logs();
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h01, a1);
    i2c_start();
    write_byte(8'hD1, a2);
    for (int i = 0; i < 3; i++) recv_bit(b);
    // Middle of the 4th bit of 0xC4: target is driving a 0
    #50 m_sda = 1'b1;
    #50 m_scl = 1'b1;
    #50;
    chk_cnt++; if (bus.sda_oen !== 1'b1) $display("FAIL rc_drive_bit3: got %b want 1", bus.sda_oen); else pass_cnt++;
    #3 areset = 1'b0;
    #1;
    chk_cnt++; if (bus.sda_oen !== 1'b0) $display("FAIL rc_oen: got %b want 0", bus.sda_oen); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rc_busy: got %b want 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL rc_wr_en: got %b want 0", bus.wr_en); else pass_cnt++;
    chk_cnt++; if (bus.wr_addr !== 8'h00) $display("FAIL rc_wr_addr: got %h want 00", bus.wr_addr); else pass_cnt++;
    chk_cnt++; if (bus.wr_data !== 8'h00) $display("FAIL rc_wr_data: got %h want 00", bus.wr_data); else pass_cnt++;
    chk_cnt++; if (bus.rd_addr !== 8'h00) $display("FAIL rc_rd_addr: got %h want 00", bus.rd_addr); else pass_cnt++;
    #100 m_scl = 1'b0;
    #50;
    @(negedge pclk) areset = 1'b1;
    #200;
    clear_logs();
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h00, a1);
    write_byte(8'h3C, a2);
    i2c_stop();
    #100;
    chk_cnt++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rc_new_acks: got %b want 000", {a0, a1, a2}); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 1) $display("FAIL rc_new_cycles: got %0d want 1", wq_addr.size()); else pass_cnt++;
    chk_cnt++; if ({wq_addr[0], wq_data[0]} !== 16'h003C) $display("FAIL rc_new_write: got %h want 003c", {wq_addr[0], wq_data[0]}); else pass_cnt++;
    chk_cnt++; if (bus.rd_addr !== 8'h01) $display("FAIL rc_ptr_inc: got %h want 01", bus.rd_addr); else pass_cnt++;
  endtask

  task automatic test_early_stop();
    logic a0, a1, a2, a3;
    clear_logs();
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_stop();
    #100;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL es_busy: got %b want 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (oen_seen !== 1'b0) $display("FAIL es_oen: got %b want 0", oen_seen); else pass_cnt++;
    // Two data bytes from reg 3 exercise the pointer wrap to 0
    i2c_start();
    write_byte(8'hD0, a0);
    write_byte(8'h03, a1);
    write_byte(8'h77, a2);
    write_byte(8'h88, a3);
    i2c_stop();
    #100;
    chk_cnt++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL es_acks: got %b want 0000", {a0, a1, a2, a3}); else pass_cnt++;
    chk_cnt++; if (wq_addr.size() !== 2) $display("FAIL es_cycles: got %0d want 2", wq_addr.size()); else pass_cnt++;
    chk_cnt++; if ({wq_addr[0], wq_data[0]} !== 16'h0377) $display("FAIL es_write0: got %h want 0377", {wq_addr[0], wq_data[0]}); else pass_cnt++;
    chk_cnt++; if ({wq_addr[1], wq_data[1]} !== 16'h0088) $display("FAIL es_write1_wrap: got %h want 0088", {wq_addr[1], wq_data[1]}); else pass_cnt++;
  endtask

  initial begin
    regs[0] = 8'h22;
    regs[1] = 8'hC4;
    regs[2] = 8'h5A;
    regs[3] = 8'h11;
    test_reset();
    test_write_one();
    test_read_ack_nack();
    test_addr_mismatch();
    test_reg_range();
    test_reset_recovery();
    test_early_stop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_i2c_slave_responder
`default_nettype wire
